i_ddr_deserializer: RTL and testbench
=====================================

// Module: i_ddr_deserializer
//
// PURPOSE
//  Receive-side counterpart of the DDR output register: samples serial pad
//  data D on both edges of C (rise = earlier bit, fall = later bit) and
//  deserializes the stream into WIDTH-bit parallel words with word-boundary
//  bitslip. Sits between the input buffer (or I_DELAY) and fabric logic.
//
// PARAMETERS
//  WIDTH  4  parallel word width; even, 4..10; other values -> $error at elaboration
//
// PORTS
//  C          in   1      clock; D sampled on both edges
//  R          in   1      reset, asynchronous, active-low
//  D          in   1      serial data from pad/buffer/I_DELAY
//  E          in   1      active-high enable; E=0 holds all state (no capture)
//  BITSLIP    in   1      slip request, sampled on rising C
//  Q          out  WIDTH  parallel word; Q[0] = earliest received bit
//  Q_VALID    out  1      one-cycle pulse: Q updated this cycle
//  SLIP_BUSY  out  1      slip accepted, not yet applied to a delivered word
//
// BEHAVIOUR
//  - Reset (R low, async, any time): Q=0, Q_VALID=0, SLIP_BUSY=0, state=IDLE,
//    slip offset OFF=0, history HIST=0, capture regs=0, counters=0.
//  - Capture (E=1): rise reg <= D on posedge C; fall reg <= D on negedge C.
//    Pair {fall,rise} is shifted in at the next posedge.
//  - HIST[2W-1:0] shifts right 2 bits per shift; new pair enters at top.
//    Word window = HIST[W-OFF +: W].
//  - FSM (posedge C, only when E=1):
//    IDLE: capture only, no shift -> FILL, FCNT=0.
//    FILL: shift pair, FCNT++.
//          On the shift with FCNT==W-1, set LOAD=1, PCNT=0, -> RUN.
//    RUN:  shift pair; PCNT wraps at W/2-1.
//          On the wrap, set LOAD=1.
//  - Output stage (every posedge, independent of E): if LOAD then Q<=window,
//    Q_VALID<=1, LOAD<=0; else Q_VALID<=0. Q holds between loads.
//  - Cadence (E=1 continuous from reset release, posedge #1 = first posedge):
//    first Q_VALID at posedge W+2, then every W/2 posedges.
//  - BITSLIP: honoured only in RUN and only when SLIP_BUSY=0.
//    Effect: OFF <= (OFF==W-1) ? 0 : OFF+1, SLIP_BUSY<=1. Each slip moves the
//    word boundary one bit earlier in the stream.
//    SLIP_BUSY clears on the posedge that asserts Q_VALID. That word uses the
//    new OFF.
//    BITSLIP in IDLE/FILL or while SLIP_BUSY=1 is ignored (no queueing).
//  - BITSLIP coinciding with a LOAD-setting posedge: the slip is accepted.
//    The imminent word uses the new OFF, and SLIP_BUSY clears with that Q_VALID.
//  - E=0: capture regs, HIST, FSM, counters, OFF frozen; a pending LOAD still
//    delivers. Resuming E=1 continues the count (no re-fill).
//  - R asserted mid-word: partial word discarded; full IDLE->FILL re-fill.
//
// TESTING (WIDTH=4, E=1; bits b0,b1,.. = rise,fall,rise,...)
//  1 Reset: R=0 with D toggling -> Q=0, Q_VALID=0, SLIP_BUSY=0 throughout.
//  2 Cadence: release R, stream b_n=n[0] -> Q_VALID at posedge 6,8,10,...
//    Q=4'b1010 each word.
//  3 Order: stream bytes 0x1,0x2,.. LSB-first -> posedge 6 Q=b7..b4,
//    Q[0]=b4; posedge 8 Q=b11..b8.
//  4 Bitslip: BITSLIP=1 for one posedge in RUN -> SLIP_BUSY=1.
//    Next word shifted one bit earlier (Q[0]=b_{4k-1}). SLIP_BUSY clears with
//    that Q_VALID. 4 slips -> OFF back to 0, original alignment.
//  5 Ignored slips: BITSLIP held high 3 posedges -> exactly one slip applied.
//    BITSLIP during FILL -> no effect.
//  6 Enable/reset: E=0 for 3 cycles mid-word -> no extra Q_VALID, stream
//    resumes aligned. R pulse mid-word -> outputs 0 at once, first Q_VALID
//    again 6 posedges after release.

Source files
------------

// File: rtl/i_ddr_deserializer.sv
// i_ddr_deserializer: samples pad data on both edges of C and assembles
// WIDTH-bit parallel words (Q[0] = earliest bit) with word-boundary bitslip.
module i_ddr_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             D,
  input  logic             E,
  input  logic             BITSLIP,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic             SLIP_BUSY
);

  localparam int HW = 2 * WIDTH;
  localparam int CW = 4;
  localparam int IW = $clog2(HW);
  localparam logic [CW-1:0] FCNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PCNT_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(WIDTH - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 10) begin : g_bad_width
    $error("i_ddr_deserializer: WIDTH must be even and within 4..10");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t          state_q;
  logic            rise_q;
  logic            fall_q;
  logic [HW-1:0]   hist_q;
  logic [HW-1:0]   hist_shift_s;
  logic [CW-1:0]   fcnt_q;
  logic [CW-1:0]   pcnt_q;
  logic [CW-1:0]   off_q;
  logic [CW-1:0]   off_d;
  logic            load_q;
  logic            load_d;
  logic            slip_take_s;
  logic [WIDTH-1:0] window_d;
  logic [IW-1:0]   idx_s;
  logic [WIDTH-1:0] q_q;
  logic            q_valid_q;
  logic            slip_busy_q;

  assign Q         = q_q;
  assign Q_VALID   = q_valid_q;
  assign SLIP_BUSY = slip_busy_q;

  // Newest pair enters at the top: fall (later bit) above rise (earlier bit).
  assign hist_shift_s = {fall_q, rise_q, hist_q[HW-1:2]};

  // A slip is taken only while running, enabled and no slip is outstanding.
  assign slip_take_s = E && BITSLIP && (state_q == ST_RUN) && !slip_busy_q;

  // Next slip offset: wraps back to zero after WIDTH-1.
  always_comb begin
    off_d = off_q;
    if (slip_take_s) begin
      off_d = (off_q == OFF_LAST) ? '0 : off_q + 4'd1;
    end else begin
      off_d = off_q;
    end
  end

  // LOAD request: last fill shift, or pair-counter wrap while running.
  always_comb begin
    load_d = 1'b0;
    if (E && (state_q == ST_FILL) && (fcnt_q == FCNT_LAST)) begin
      load_d = 1'b1;
    end else if (E && (state_q == ST_RUN) && (pcnt_q == PCNT_LAST)) begin
      load_d = 1'b1;
    end else begin
      load_d = 1'b0;
    end
  end

  // Word window HIST[WIDTH-OFF +: WIDTH]; uses the offset as of this cycle.
  always_comb begin
    window_d = '0;
    idx_s    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx_s       = IW'(i + WIDTH) - IW'(off_q);
      window_d[i] = hist_q[idx_s];
    end
  end

  // Falling-edge capture of the later bit of each pair.
  always_ff @(negedge C or negedge R) begin
    if (!R) begin
      fall_q <= 1'b0;
    end else if (E) begin
      fall_q <= D;
    end else begin
      fall_q <= fall_q;
    end
  end

  // Rise capture, history shifting, fill/run sequencing and slip offset.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      rise_q  <= 1'b0;
      hist_q  <= '0;
      fcnt_q  <= '0;
      pcnt_q  <= '0;
      off_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      load_q <= load_d;
      off_q  <= off_d;
      if (E) begin
        rise_q <= D;
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_FILL;
            fcnt_q  <= '0;
          end
          ST_FILL: begin
            hist_q <= hist_shift_s;
            fcnt_q <= fcnt_q + 4'd1;
            if (fcnt_q == FCNT_LAST) begin
              pcnt_q  <= '0;
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            hist_q <= hist_shift_s;
            if (pcnt_q == PCNT_LAST) begin
              pcnt_q <= '0;
            end else begin
              pcnt_q <= pcnt_q + 4'd1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Output stage: deliver a loaded word and track slip-in-flight status.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      slip_busy_q <= 1'b0;
    end else begin
      if (load_q) begin
        q_q       <= window_d;
        q_valid_q <= 1'b1;
      end else begin
        q_valid_q <= 1'b0;
      end
      if (slip_take_s) begin
        slip_busy_q <= 1'b1;
      end else if (load_q) begin
        slip_busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i_ddr_deserializer.sv
// Bench for i_ddr_deserializer: stream-index reference model plus literal words.
module tb_i_ddr_deserializer;

  localparam int W = 4;

  logic C = 1'b0;
  logic R = 1'b1;
  logic D = 1'b0;
  logic E = 1'b1;
  logic BITSLIP = 1'b0;
  logic [W-1:0] Q;
  logic Q_VALID;
  logic SLIP_BUSY;

  i_ddr_deserializer #(.WIDTH(W)) dut (
    .C(C), .R(R), .D(D), .E(E), .BITSLIP(BITSLIP),
    .Q(Q), .Q_VALID(Q_VALID), .SLIP_BUSY(SLIP_BUSY)
  );

  always #5 C = ~C;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words are read straight out of the received bit stream.
  logic       stream[$];
  logic [W-1:0] dut_words[$];
  int         en_cnt, off, pcount, base;
  logic       m_busy, pend, m_qv, dlv, acc, all_en, seen_first;
  logic [W-1:0] m_q, pend_word;

  always @(negedge C) begin
    if (R && E) stream.push_back(D);
  end

  always @(posedge C) begin
    if (!R) begin
      en_cnt = 0; off = 0; m_busy = 1'b0; pend = 1'b0; m_q = '0; m_qv = 1'b0;
      pcount = 0; all_en = 1'b1; seen_first = 1'b0;
      stream.delete(); dut_words.delete();
    end else begin
      pcount++;
      if (!E) all_en = 1'b0;
      dlv = pend;
      if (dlv) begin m_q = pend_word; m_qv = 1'b1; end else m_qv = 1'b0;
      acc = E && BITSLIP && (en_cnt >= W + 1) && !m_busy;
      if (acc) m_busy = 1'b1; else if (dlv) m_busy = 1'b0;
      pend = 1'b0;
      if (E) begin
        stream.push_back(D);
        en_cnt++;
        if (acc) off = (off + 1) % W;
        if (en_cnt == W + 1 || (en_cnt > W + 1 && (en_cnt - (W + 1)) % (W / 2) == 0)) begin
          pend = 1'b1;
          base = 2 * (en_cnt - 1) - W - off;
          for (int i = 0; i < W; i++) pend_word[i] = stream[base + i];
        end
      end
    end
    #1;
    chk("q", 32'(Q), 32'(m_q));
    chk("q_valid", 32'(Q_VALID), 32'(m_qv));
    chk("slip_busy", 32'(SLIP_BUSY), 32'(m_busy));
    if (R && Q_VALID) begin
      dut_words.push_back(Q);
      if (!seen_first && all_en) chk("first_valid_edge", 32'(pcount), 32'd6);
      seen_first = 1'b1;
    end
  end

  // Stimulus generation.
  int mode = 0;
  int sidx = 0;

  function automatic logic gen(input int idx);
    logic [31:0] v;
    int sh;
    if (mode == 1) begin v = 32'(idx); sh = 0; end
    else if (mode == 2) begin v = 32'(idx / 8 + 1); sh = idx % 8; end
    else begin v = $urandom; sh = 0; end
    return v[sh];
  endfunction

  // One C period: rise bit presented before posedge, fall bit before negedge.
  task automatic step(input logic e, input logic bs, input logic r);
    logic rb, fb;
    @(negedge C); #2;
    if (r && e) begin
      rb = gen(sidx); fb = gen(sidx + 1); sidx += 2;
    end else begin
      rb = 1'($urandom % 2); fb = 1'($urandom % 2);
      if (!r) sidx = 0;
    end
    R = r; E = e; BITSLIP = bs; D = rb;
    @(posedge C); #2;
    D = fb;
  endtask

  task automatic chkw(input string nm, input int k, input logic [W-1:0] expw);
    if (k >= 0 && k < dut_words.size()) chk(nm, 32'(dut_words[k]), 32'(expw));
    else chk({nm, "_missing"}, 32'(dut_words.size()), 32'(k + 1));
  endtask

  task automatic mid_reset();
    @(posedge C); #3;
    R = 1'b0;
    #1;
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_q_valid", 32'(Q_VALID), 32'd0);
    chk("rst_slip_busy", 32'(SLIP_BUSY), 32'd0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1 R = 1'b0;
    mode = 0;
    repeat (4) step(1'b1, 1'b0, 1'b0);

    // Cadence with alternating bits.
    mode = 1;
    step(1'b1, 1'b0, 1'b1);
    repeat (13) step(1'b1, 1'b0, 1'b1);
    chkw("t2_word0", 0, 4'b1010);
    chkw("t2_word3", 3, 4'b1010);

    // Single slip, then three more returning to original alignment.
    step(1'b1, 1'b1, 1'b1);
    repeat (8) step(1'b1, 1'b0, 1'b1);
    chkw("slip1_word", dut_words.size() - 1, 4'b0101);
    repeat (3) begin
      step(1'b1, 1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0, 1'b1);
    end
    chkw("slip4_word", dut_words.size() - 1, 4'b1010);

    // BITSLIP held three posedges starting on a delivery edge: one slip.
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b1);
    chkw("held_slip_word", dut_words.size() - 1, 4'b0101);

    // Reset mid-word, slips during fill are ignored.
    mid_reset();
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    repeat (8) step(1'b1, 1'b0, 1'b1);
    chkw("fill_slip_word", dut_words.size() - 1, 4'b1010);

    // Enable low for three cycles mid-word, stream stays aligned.
    repeat (3) step(1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b1);
    chkw("enable_word", dut_words.size() - 1, 4'b1010);

    // Byte ordering: bytes 0x01, 0x02, 0x03 LSB-first.
    mid_reset();
    mode = 2;
    step(1'b1, 1'b0, 1'b1);
    repeat (11) step(1'b1, 1'b0, 1'b1);
    chkw("order_word0", 0, 4'b0000);
    chkw("order_word1", 1, 4'b0010);
    chkw("order_word3", 3, 4'b0011);

    // Randomized traffic with enable gaps, slips and occasional resets.
    mode = 0;
    repeat (400) begin
      step(1'(($urandom % 8) != 0), 1'(($urandom % 6) == 0), 1'(($urandom % 100) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
